// File: rtl/hash160_rr_scheduler_if.sv
// Requester byte lanes, hash-core start/done and response channel of the Hash160 scheduler.
// The scheduler drives through the master modport; requesters, core and consumer use slave.
interface hash160_rr_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int REQ_W = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_byte;
    logic [N_REQ-1:0]   req_ready;
    logic               core_start;
    logic [511:0]       core_block;
    logic               core_done;
    logic [159:0]       core_digest;
    logic               rsp_valid;
    logic [REQ_W-1:0]   rsp_id;
    logic [159:0]       rsp_digest;
    logic               rsp_ready;
    logic               abort_err;
    logic               busy;

    modport master (
        input  req_valid, req_byte, core_done, core_digest, rsp_ready,
        output req_ready, core_start, core_block, rsp_valid, rsp_id, rsp_digest,
               abort_err, busy
    );

    modport slave (
        output req_valid, req_byte, core_done, core_digest, rsp_ready,
        input  req_ready, core_start, core_block, rsp_valid, rsp_id, rsp_digest,
               abort_err, busy
    );
endinterface

// File: rtl/hash160_rr_scheduler.sv
// Round-robin scheduler sharing one Hash160 core: grant a requester, load 64 bytes,
// start the core, wait for done and return the digest tagged with the requester id.
module hash160_rr_scheduler #(
    parameter int N_REQ       = 4,
    parameter int REQ_W       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hash160_rr_scheduler_if.master bus
);
    localparam int          IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned NR     = N_REQ;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [REQ_W-1:0]  gnt, last_grant, winner, cand;
    logic              any_req, gnt_valid, xfer, timeout;
    logic [7:0]        lane_byte;
    logic [5:0]        cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [511:0]      block_q;
    logic [159:0]      digest_q;
    logic [REQ_W-1:0]  id_q;
    logic [N_REQ-1:0]  ready_c;

    // First requesting index after last_grant, wrapping modulo N_REQ.
    always_comb begin
        winner  = last_grant;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            cand = REQ_W'((32'(last_grant) + i) % NR);
            if (!any_req && bus.req_valid[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        lane_byte = '0;
        gnt_valid = 1'b0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (gnt == REQ_W'(i)) begin
                lane_byte = bus.req_byte[8*i +: 8];
                gnt_valid = bus.req_valid[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        xfer     = 1'b0;
        timeout  = 1'b0;
        ready_c  = '0;
        case (state)
            IDLE: if (any_req) state_nx = LOAD;
            LOAD: begin
                for (int unsigned i = 0; i < NR; i++) ready_c[i] = (gnt == REQ_W'(i));
                if (gnt_valid) begin
                    xfer = 1'b1;
                    if (cnt == 6'd63) state_nx = START;
                end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end
            end
            START: state_nx = WAIT;
            WAIT:  if (bus.core_done) state_nx = RESP;
            RESP:  if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt        <= '0;
            last_grant <= REQ_W'(N_REQ - 1);
            cnt        <= '0;
            idle_cnt   <= '0;
            block_q    <= '0;
            digest_q   <= '0;
            id_q       <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt      <= winner;
                    cnt      <= '0;
                    idle_cnt <= '0;
                end
                LOAD: begin
                    if (xfer) begin
                        for (int unsigned j = 0; j < 64; j++) begin
                            if (cnt == 6'(j)) block_q[511 - 8*j -: 8] <= lane_byte;
                        end
                        cnt      <= cnt + 6'd1;
                        idle_cnt <= '0;
                    end else if (timeout) begin
                        last_grant <= gnt;
                        idle_cnt   <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                WAIT: if (bus.core_done) begin
                    digest_q <= bus.core_digest;
                    id_q     <= gnt;
                end
                RESP: if (bus.rsp_ready) last_grant <= gnt;
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.core_start = (state == START);
    assign bus.core_block = block_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_digest = digest_q;
    assign bus.abort_err  = timeout;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_hash160_rr_scheduler.sv
// Bench for hash160_rr_scheduler: scripted requesters, a fixed-latency core model and a
// round-robin job-order model; every task compares what it observed against expectations.
`timescale 1ns/1ps
module tb_hash160_rr_scheduler;
    localparam int N = 4, RW = 2, TO = 255, CORE_LAT = 10, MAXB = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hash160_rr_scheduler_if #(.N_REQ(N), .REQ_W(RW)) bus ();
    hash160_rr_scheduler #(.N_REQ(N), .REQ_W(RW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    int pass_cnt = 0, chk_cnt = 0;
    logic [7:0] src [N][MAXB];
    int src_len [N], src_ptr [N], hold_at [N], hold_left [N];
    bit rand_gap, rand_rsp, rsp_rdy_man;
    int cyc, cd, done_cnt, start_cnt, abort_cnt, abort_stall, stall_run, onehot_err, hold_noready;
    int job_x, job_mask;
    logic [159:0] cd_dig;
    logic [N-1:0] prev_ready;
    logic drv_v;
    int grant_q[$], grant_cyc_q[$], jx_q[$], jmask_q[$], rcyc_q[$];
    logic [RW-1:0] rid_q[$];
    logic [159:0] rdig_q[$];
    logic [511:0] blk_q[$];

    function automatic logic [159:0] dig(input logic [511:0] b);
        return b[511:352] ^ b[351:192] ^ b[191:32] ^ {b[31:0], 128'h0}
             ^ 160'h0123456789abcdeffedcba98765432100f1e2d3c;
    endfunction

    function automatic logic [511:0] exp_blk(input int l, input int j);
        logic [511:0] b;
        for (int k = 0; k < 64; k++) b[511 - 8*k -: 8] = src[l][64*j + k];
        return b;
    endfunction

    function automatic int lane_of(input logic [N-1:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return -1;
    endfunction

    // Requesters, core model, response consumer and monitors, all on the falling edge.
    always @(negedge clk) begin
        cyc++;
        bus.rsp_ready = rand_rsp ? 1'($urandom_range(0, 1)) : rsp_rdy_man;
        bus.core_done = 1'b0;
        if (bus.core_start === 1'b1) begin
            start_cnt++;
            cd     = CORE_LAT;
            cd_dig = dig(bus.core_block);
            blk_q.push_back(bus.core_block);
            jx_q.push_back(job_x);
            jmask_q.push_back(job_mask);
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                bus.core_done   = 1'b1;
                bus.core_digest = cd_dig;
                done_cnt++;
            end
        end
        for (int i = 0; i < N; i++) begin
            drv_v = (src_ptr[i] < src_len[i]);
            if (drv_v && hold_left[i] > 0 && src_ptr[i] == hold_at[i]) begin
                drv_v = 1'b0;
                hold_left[i]--;
                if (bus.req_ready[i] !== 1'b1) hold_noready++;
            end
            if (drv_v && rand_gap && bus.req_ready[i] === 1'b1 && $urandom_range(0, 3) == 0)
                drv_v = 1'b0;
            bus.req_valid[i] = drv_v;
            bus.req_byte[8*i +: 8] = (src_ptr[i] < src_len[i]) ? src[i][src_ptr[i]] : 8'($urandom);
        end
        if ($countones(bus.req_ready) > 1) onehot_err++;
        if (bus.req_ready != '0 && prev_ready == '0) begin
            grant_q.push_back(lane_of(bus.req_ready));
            grant_cyc_q.push_back(cyc);
            job_x    = 0;
            job_mask = 0;
        end
        if (bus.req_ready != '0) begin
            if ((bus.req_ready & bus.req_valid) != '0) begin
                for (int i = 0; i < N; i++)
                    if (bus.req_ready[i] && bus.req_valid[i]) begin
                        src_ptr[i]++;
                        job_x++;
                        job_mask |= (1 << i);
                    end
                stall_run = 0;
            end else stall_run++;
        end else stall_run = 0;
        if (bus.abort_err === 1'b1) begin
            abort_cnt++;
            abort_stall = stall_run;
        end
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
            rid_q.push_back(bus.rsp_id);
            rdig_q.push_back(bus.rsp_digest);
            rcyc_q.push_back(cyc);
        end
        prev_ready = bus.req_ready;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_env();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0; src_ptr[i] = 0; hold_at[i] = 0; hold_left[i] = 0;
        end
        rand_gap = 0; rand_rsp = 0; rsp_rdy_man = 1;
        done_cnt = 0; start_cnt = 0; abort_cnt = 0; abort_stall = 0; onehot_err = 0; hold_noready = 0;
        grant_q.delete(); grant_cyc_q.delete(); jx_q.delete(); jmask_q.delete();
        rid_q.delete(); rdig_q.delete(); rcyc_q.delete(); blk_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic load_job(input int l, input int j, input bit ramp);
        for (int k = 0; k < 64; k++) src[l][64*j + k] = ramp ? 8'(k) : 8'($urandom);
        src_len[l] = 64 * (j + 1);
    endtask

    task automatic wait_resp(input int n, input int budget, output bit ok);
        int t;
        t = 0;
        while (rid_q.size() < n && t < budget) begin
            step();
            t++;
        end
        ok = (rid_q.size() >= n);
    endtask

    task automatic test_reset();
        clear_env();
        rst_n = 1'b0;
        step();
        chk_cnt++; if (bus.req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); else pass_cnt++;
        chk_cnt++; if ({bus.core_start, bus.rsp_valid, bus.abort_err, bus.busy} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {bus.core_start, bus.rsp_valid, bus.abort_err, bus.busy}); else pass_cnt++;
        chk_cnt++; if (bus.core_block !== '0) $display("FAIL reset_core_block: got %h want 0", bus.core_block); else pass_cnt++;
        chk_cnt++; if ({bus.rsp_id, bus.rsp_digest} !== '0) $display("FAIL reset_rsp: got %h want 0", {bus.rsp_id, bus.rsp_digest}); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit ok;
        logic [511:0] ramp_blk;
        for (int k = 0; k < 64; k++) ramp_blk[511 - 8*k -: 8] = 8'(k);
        clear_env();
        load_job(0, 0, 1'b1);
        wait_resp(1, 300, ok);
        step();
        chk_cnt++; if (!ok) $display("FAIL single_resp: got %0d responses want 1", rid_q.size()); else pass_cnt++;
        chk_cnt++; if (start_cnt !== 1) $display("FAIL single_starts: got %0d want 1", start_cnt); else pass_cnt++;
        chk_cnt++; if (blk_q[0] !== ramp_blk) $display("FAIL single_block: got %h want %h", blk_q[0], ramp_blk); else pass_cnt++;
        chk_cnt++; if (rid_q[0] !== 2'd0) $display("FAIL single_id: got %0d want 0", rid_q[0]); else pass_cnt++;
        chk_cnt++; if (rdig_q[0] !== dig(ramp_blk)) $display("FAIL single_digest: got %h want %h", rdig_q[0], dig(ramp_blk)); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_idle_after: got busy=%b want 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_g[5] = '{0, 1, 2, 3, 0};
        int exp_j[5] = '{0, 0, 0, 0, 1};
        do_reset();
        clear_env();
        load_job(0, 0, 1'b0); load_job(0, 1, 1'b0);
        for (int l = 1; l < N; l++) load_job(l, 0, 1'b0);
        wait_resp(5, 800, ok);
        chk_cnt++; if (!ok) $display("FAIL rr_resp: got %0d responses want 5", rid_q.size()); else pass_cnt++;
        for (int e = 0; e < 5; e++) begin
            chk_cnt++; if (grant_q[e] !== exp_g[e]) $display("FAIL rr_grant%0d: got %0d want %0d", e, grant_q[e], exp_g[e]); else pass_cnt++;
            chk_cnt++; if (jx_q[e] !== 64 || jmask_q[e] !== (1 << exp_g[e]))
                $display("FAIL rr_strobes%0d: got %0d on mask %b want 64 on %b", e, jx_q[e], jmask_q[e], 1 << exp_g[e]); else pass_cnt++;
            chk_cnt++; if (rid_q[e] !== RW'(exp_g[e]) || rdig_q[e] !== dig(exp_blk(exp_g[e], exp_j[e])))
                $display("FAIL rr_rsp%0d: got id %0d dig %h want id %0d dig %h", e, rid_q[e], rdig_q[e], exp_g[e], dig(exp_blk(exp_g[e], exp_j[e]))); else pass_cnt++;
        end
        chk_cnt++; if (onehot_err !== 0) $display("FAIL rr_onehot: got %0d multi-bit cycles want 0", onehot_err); else pass_cnt++;
    endtask

    task automatic test_stall();
        bit ok;
        clear_env();
        load_job(2, 0, 1'b0);
        hold_at[2] = 31; hold_left[2] = 5;
        wait_resp(1, 300, ok);
        chk_cnt++; if (!ok || hold_left[2] !== 0) $display("FAIL stall_done: got resp=%0d hold_left=%0d want 1 and 0", rid_q.size(), hold_left[2]); else pass_cnt++;
        chk_cnt++; if (hold_noready !== 0) $display("FAIL stall_ready: got %0d cycles without ready want 0", hold_noready); else pass_cnt++;
        chk_cnt++; if (blk_q[0] !== exp_blk(2, 0)) $display("FAIL stall_block: got %h want %h", blk_q[0], exp_blk(2, 0)); else pass_cnt++;
        chk_cnt++; if (jx_q[0] !== 64) $display("FAIL stall_count: got %0d transfers want 64", jx_q[0]); else pass_cnt++;
        chk_cnt++; if (rid_q[0] !== 2'd2 || rdig_q[0] !== dig(exp_blk(2, 0)))
            $display("FAIL stall_rsp: got id %0d dig %h want id 2 dig %h", rid_q[0], rdig_q[0], dig(exp_blk(2, 0))); else pass_cnt++;
        chk_cnt++; if (abort_cnt !== 0) $display("FAIL stall_abort: got %0d aborts want 0", abort_cnt); else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit ok;
        int t;
        do_reset();
        clear_env();
        load_job(1, 0, 1'b0);
        hold_at[1] = 11; hold_left[1] = 300;
        t = 0;
        while (abort_cnt == 0 && t < 400) begin step(); t++; end
        repeat (5) step();
        chk_cnt++; if (abort_cnt !== 1) $display("FAIL to_abort_count: got %0d want 1", abort_cnt); else pass_cnt++;
        chk_cnt++; if (abort_stall !== TO) $display("FAIL to_abort_cycle: got idle cycle %0d want %0d", abort_stall, TO); else pass_cnt++;
        chk_cnt++; if (start_cnt !== 0 || src_ptr[1] !== 11) $display("FAIL to_no_start: got starts=%0d bytes=%0d want 0 and 11", start_cnt, src_ptr[1]); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL to_idle: got busy=%b want 0", bus.busy); else pass_cnt++;
        hold_left[1] = 0; src_ptr[1] = 0;
        load_job(2, 0, 1'b0);
        wait_resp(2, 400, ok);
        chk_cnt++; if (!ok) $display("FAIL to_resp: got %0d responses want 2", rid_q.size()); else pass_cnt++;
        chk_cnt++; if (grant_q[1] !== 2 || grant_q[2] !== 1) $display("FAIL to_next_grant: got %0d,%0d want 2,1", grant_q[1], grant_q[2]); else pass_cnt++;
        chk_cnt++; if (rid_q[0] !== 2'd2 || rdig_q[0] !== dig(exp_blk(2, 0)) || rid_q[1] !== 2'd1 || rdig_q[1] !== dig(exp_blk(1, 0)))
            $display("FAIL to_rsp_data: got ids %0d,%0d want 2,1 with model digests", rid_q[0], rid_q[1]); else pass_cnt++;
    endtask

    task automatic test_resp_hold();
        bit ok;
        int t, bad_hold, bad_ready;
        logic [159:0] ed;
        clear_env();
        rsp_rdy_man = 0;
        load_job(3, 0, 1'b0);
        ed = dig(exp_blk(3, 0));
        t = 0;
        while (grant_q.size() == 0 && t < 20) begin step(); t++; end
        load_job(0, 0, 1'b0);
        t = 0;
        while (bus.rsp_valid !== 1'b1 && t < 300) begin step(); t++; end
        chk_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL hold_rsp_valid: got %b want 1", bus.rsp_valid); else pass_cnt++;
        bad_hold = 0; bad_ready = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_digest !== ed) bad_hold++;
            if (bus.req_ready !== '0) bad_ready++;
            step();
        end
        chk_cnt++; if (bad_hold !== 0) $display("FAIL hold_stable: got %0d unstable cycles want 0", bad_hold); else pass_cnt++;
        chk_cnt++; if (bad_ready !== 0) $display("FAIL hold_ready_low: got %0d cycles with ready want 0", bad_ready); else pass_cnt++;
        chk_cnt++; if (grant_q.size() !== 1) $display("FAIL hold_no_grant: got %0d grants want 1", grant_q.size()); else pass_cnt++;
        rsp_rdy_man = 1;
        wait_resp(2, 300, ok);
        chk_cnt++; if (!ok || rid_q[0] !== 2'd3 || rdig_q[0] !== ed) $display("FAIL hold_first_rsp: got id %0d dig %h want 3 %h", rid_q[0], rdig_q[0], ed); else pass_cnt++;
        chk_cnt++; if (grant_q[1] !== 0 || grant_cyc_q[1] <= rcyc_q[0])
            $display("FAIL hold_grant_after: got lane %0d at cycle %0d want lane 0 after %0d", grant_q[1], grant_cyc_q[1], rcyc_q[0]); else pass_cnt++;
    endtask

    task automatic test_reset_wait();
        bit ok;
        int t;
        clear_env();
        load_job(1, 0, 1'b0);
        t = 0;
        while (start_cnt == 0 && t < 200) begin step(); t++; end
        repeat (3) step();
        chk_cnt++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) $display("FAIL rw_in_wait: got busy=%b rsp_valid=%b want 1 0", bus.busy, bus.rsp_valid); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if ({bus.req_ready, bus.core_start, bus.core_block, bus.rsp_valid, bus.rsp_id, bus.rsp_digest, bus.abort_err, bus.busy} !== '0)
            $display("FAIL rw_async_clear: got busy=%b block=%h want all 0", bus.busy, bus.core_block); else pass_cnt++;
        step(); step();
        rst_n = 1'b1;
        t = 0;
        while (done_cnt == 0 && t < 30) begin step(); t++; end
        repeat (3) step();
        chk_cnt++; if (done_cnt !== 1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || rid_q.size() !== 0)
            $display("FAIL rw_done_ignored: got done=%0d rsp_valid=%b busy=%b resp=%0d want 1 0 0 0", done_cnt, bus.rsp_valid, bus.busy, rid_q.size()); else pass_cnt++;
        load_job(0, 0, 1'b0);
        load_job(3, 0, 1'b0);
        wait_resp(2, 400, ok);
        chk_cnt++; if (!ok || grant_q[1] !== 0 || grant_q[2] !== 3) $display("FAIL rw_next_grant: got %0d,%0d want 0,3", grant_q[1], grant_q[2]); else pass_cnt++;
        chk_cnt++; if (rid_q[0] !== 2'd0 || rdig_q[0] !== dig(exp_blk(0, 0))) $display("FAIL rw_rsp: got id %0d dig %h want 0 %h", rid_q[0], rdig_q[0], dig(exp_blk(0, 0))); else pass_cnt++;
    endtask

    task automatic test_random();
        bit ok;
        int jobs[N], rem[N], exp_id[$], exp_job[$];
        int total, last, c;
        last = N - 1;
        do_reset();
        for (int round = 0; round < 3; round++) begin
            clear_env();
            rand_gap = 1; rand_rsp = 1;
            total = 0;
            for (int l = 0; l < N; l++) begin
                jobs[l] = $urandom_range(0, 2);
                if (round == 0 && l == 0 && jobs[l] == 0) jobs[l] = 1;
                for (int j = 0; j < jobs[l]; j++) load_job(l, j, 1'b0);
                rem[l] = jobs[l];
                total += jobs[l];
            end
            exp_id.delete(); exp_job.delete();
            for (int e = 0; e < total; e++) begin
                for (int k = 1; k <= N; k++) begin
                    c = (last + k) % N;
                    if (rem[c] > 0) begin
                        exp_id.push_back(c);
                        exp_job.push_back(jobs[c] - rem[c]);
                        rem[c]--;
                        last = c;
                        break;
                    end
                end
            end
            wait_resp(total, 200 * total + 50, ok);
            chk_cnt++; if (!ok) $display("FAIL rand%0d_count: got %0d responses want %0d", round, rid_q.size(), total); else pass_cnt++;
            for (int e = 0; e < total; e++) begin
                chk_cnt++; if (rid_q[e] !== RW'(exp_id[e]) || rdig_q[e] !== dig(exp_blk(exp_id[e], exp_job[e])))
                    $display("FAIL rand%0d_rsp%0d: got id %0d dig %h want id %0d dig %h", round, e, rid_q[e], rdig_q[e],
                             exp_id[e], dig(exp_blk(exp_id[e], exp_job[e]))); else pass_cnt++;
            end
            chk_cnt++; if (onehot_err !== 0 || abort_cnt !== 0) $display("FAIL rand%0d_sanity: got onehot_err=%0d aborts=%0d want 0 0", round, onehot_err, abort_cnt); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_timeout();
        test_resp_hold();
        test_reset_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
